// File: rtl/lfsr_prbs_gen_if.sv
// Control/status bundle for lfsr_prbs_gen: the master side drives the advance
// and load controls, and the slave side (the generator) returns state, output bits and period tracking.
interface lfsr_prbs_gen_if #(
    parameter int WIDTH   = 16,
    parameter int STEP    = 1,
    parameter int COUNT_W = 32
);
    logic               en;
    logic               load;
    logic               mode;
    logic [WIDTH-1:0]   seed;
    logic [WIDTH-1:0]   q;
    logic [STEP-1:0]    bits;
    logic [COUNT_W-1:0] count;
    logic               wrap;
    logic               zero_seed;

    modport master (
        output en, load, mode, seed,
        input  q, bits, count, wrap, zero_seed
    );

    modport slave (
        input  en, load, mode, seed,
        output q, bits, count, wrap, zero_seed
    );
endinterface

// File: rtl/lfsr_prbs_gen.sv
// Runtime Fibonacci/Galois LFSR with seed load, zero-seed guard, STEP-fold
// advance per enabled cycle and period tracking against the last start point.
module lfsr_prbs_gen #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] FIB_TAPS = WIDTH'(16'h002D),
    parameter logic [WIDTH-1:0] GAL_TAPS = WIDTH'(16'hB400),
    parameter int               STEP     = 1,
    parameter int               COUNT_W  = 32
) (
    input  logic          clk,
    input  logic          reset,
    lfsr_prbs_gen_if.slave bus
);

    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   start_q, start_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [STEP-1:0]    bits_q, bits_d;
    logic               wrap_q, wrap_d;
    logic               zero_seed_q, zero_seed_d;

    logic [WIDTH-1:0]   adv_state;
    logic [STEP-1:0]    adv_bits;
    logic [WIDTH-1:0]   seed_fix;
    logic               seed_zero;

    function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] s, input logic gal);
        logic [WIDTH-1:0] r;
        if (gal) r = {1'b0, s[WIDTH-1:1]} ^ (s[0] ? GAL_TAPS : '0);
        else     r = {^(s & FIB_TAPS), s[WIDTH-1:1]};
        return r;
    endfunction

    // Unrolled STEP single-steps; bit j is the LSB seen before step j.
    always_comb begin
        adv_state = q_q;
        adv_bits  = '0;
        for (int j = 0; j < STEP; j++) begin
            adv_bits[j] = adv_state[0];
            adv_state   = step1(adv_state, bus.mode);
        end
    end

    assign seed_zero = (bus.seed == '0);
    assign seed_fix  = seed_zero ? '1 : bus.seed;

    always_comb begin
        q_d         = q_q;
        start_d     = start_q;
        count_d     = count_q;
        bits_d      = bits_q;
        wrap_d      = 1'b0;
        zero_seed_d = 1'b0;
        if (bus.load) begin
            q_d         = seed_fix;
            start_d     = seed_fix;
            count_d     = '0;
            bits_d      = '0;
            zero_seed_d = seed_zero;
        end else if (bus.en) begin
            q_d    = adv_state;
            bits_d = adv_bits;
            if (adv_state == start_q) begin
                wrap_d  = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_q + COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q         <= '1;
            start_q     <= '1;
            count_q     <= '0;
            bits_q      <= '0;
            wrap_q      <= 1'b0;
            zero_seed_q <= 1'b0;
        end else begin
            q_q         <= q_d;
            start_q     <= start_d;
            count_q     <= count_d;
            bits_q      <= bits_d;
            wrap_q      <= wrap_d;
            zero_seed_q <= zero_seed_d;
        end
    end

    assign bus.q         = q_q;
    assign bus.bits      = bits_q;
    assign bus.count     = count_q;
    assign bus.wrap      = wrap_q;
    assign bus.zero_seed = zero_seed_q;

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Scoreboard bench: three generator configurations (16-bit STEP=1, 16-bit STEP=2, 8-bit STEP=1).
module tb_lfsr_prbs_gen;

    logic clk = 1'b0;
    logic rst0, rst1, rst2;
    always #5 clk = ~clk;

    lfsr_prbs_gen_if #(.WIDTH(16), .STEP(1), .COUNT_W(32)) if0 ();
    lfsr_prbs_gen_if #(.WIDTH(16), .STEP(2), .COUNT_W(32)) if1 ();
    lfsr_prbs_gen_if #(.WIDTH(8),  .STEP(1), .COUNT_W(8))  if2 ();

    lfsr_prbs_gen #(.WIDTH(16), .STEP(1), .COUNT_W(32)) u0 (.clk(clk), .reset(rst0), .bus(if0));
    lfsr_prbs_gen #(.WIDTH(16), .STEP(2), .COUNT_W(32)) u1 (.clk(clk), .reset(rst1), .bus(if1));
    lfsr_prbs_gen #(.WIDTH(8), .FIB_TAPS(8'h1D), .GAL_TAPS(8'hB8), .STEP(1), .COUNT_W(8))
        u2 (.clk(clk), .reset(rst2), .bus(if2));

    typedef struct {
        logic [31:0] q, bits, cnt;
        logic        wrap, zs;
    } exp_t;
    exp_t sb[$];

    int          W[3]  = '{16, 16, 8};
    int          S[3]  = '{1, 2, 1};
    logic [31:0] FT[3] = '{32'h2D, 32'h2D, 32'h1D};
    logic [31:0] GT[3] = '{32'hB400, 32'hB400, 32'hB8};
    logic [31:0] CM[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFF};

    logic [31:0] m_q[3], m_st[3], m_cnt[3], m_bits[3];
    logic [31:0] a_q, a_bits, a_cnt;
    logic        a_wrap, a_zs;
    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mstep(input int d, input logic [31:0] s, input bit md);
        logic [31:0] r;
        logic        fb;
        if (md) begin
            r = s >> 1;
            if (s[0]) r = r ^ GT[d];
        end else begin
            fb = 1'b0;
            for (int i = 0; i < W[d]; i++) if (FT[d][i]) fb = fb ^ s[i];
            r = (s >> 1) | (32'(fb) << (W[d] - 1));
        end
        return r;
    endfunction

    task automatic drv(input int d, input bit r, input bit ld, input bit en,
                       input logic [31:0] seed, input bit md, input string tag);
        exp_t        e;
        logic [31:0] mk, s, b;
        rst0 = 0; rst1 = 0; rst2 = 0;
        if0.en = 0; if0.load = 0; if1.en = 0; if1.load = 0; if2.en = 0; if2.load = 0;
        case (d)
            0: begin rst0 = r; if0.load = ld; if0.en = en; if0.seed = seed[15:0]; if0.mode = md; end
            1: begin rst1 = r; if1.load = ld; if1.en = en; if1.seed = seed[15:0]; if1.mode = md; end
            default: begin rst2 = r; if2.load = ld; if2.en = en; if2.seed = seed[7:0]; if2.mode = md; end
        endcase
        mk = (32'h1 << W[d]) - 1;
        e.wrap = 1'b0;
        e.zs   = 1'b0;
        if (r) begin
            m_q[d] = mk; m_st[d] = mk; m_cnt[d] = 0; m_bits[d] = 0;
        end else if (ld) begin
            s = seed & mk;
            e.zs = (s == 0);
            if (s == 0) s = mk;
            m_q[d] = s; m_st[d] = s; m_cnt[d] = 0; m_bits[d] = 0;
        end else if (en) begin
            b = 0;
            for (int j = 0; j < S[d]; j++) begin
                b[j]   = m_q[d][0];
                m_q[d] = mstep(d, m_q[d], md);
            end
            m_bits[d] = b;
            e.wrap    = (m_q[d] == m_st[d]);
            m_cnt[d]  = e.wrap ? 32'd0 : ((m_cnt[d] + 1) & CM[d]);
        end
        e.q = m_q[d]; e.bits = m_bits[d]; e.cnt = m_cnt[d];
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        case (d)
            0: begin a_q = 32'(if0.q); a_bits = 32'(if0.bits); a_cnt = 32'(if0.count);
                     a_wrap = if0.wrap; a_zs = if0.zero_seed; end
            1: begin a_q = 32'(if1.q); a_bits = 32'(if1.bits); a_cnt = 32'(if1.count);
                     a_wrap = if1.wrap; a_zs = if1.zero_seed; end
            default: begin a_q = 32'(if2.q); a_bits = 32'(if2.bits); a_cnt = 32'(if2.count);
                     a_wrap = if2.wrap; a_zs = if2.zero_seed; end
        endcase
        chk({tag, "_q"},    a_q,           e.q);
        chk({tag, "_bits"}, a_bits,        e.bits);
        chk({tag, "_cnt"},  a_cnt,         e.cnt);
        chk({tag, "_wrap"}, 32'(a_wrap),   32'(e.wrap));
        chk({tag, "_zs"},   32'(a_zs),     32'(e.zs));
    endtask

    task automatic full_period(input int d, input int n, input string tag);
        int wraps = 0, idx = 0;
        for (int i = 0; i < n; i++) begin
            drv(d, 0, 0, 1, 0, (tag == "t4g") ? 1'b1 : 1'b0, tag);
            if (a_wrap) begin wraps++; idx = i + 1; end
        end
        chk({tag, "_nwrap"}, 32'(wraps), 32'd1);
        chk({tag, "_idx"},   32'(idx),   32'(n));
        chk({tag, "_endc"},  a_cnt,      32'd0);
    endtask

    initial begin
        rst0 = 1; rst1 = 1; rst2 = 1;
        if0.en = 0; if0.load = 0; if0.seed = '0; if0.mode = 0;
        if1.en = 0; if1.load = 0; if1.seed = '0; if1.mode = 0;
        if2.en = 0; if2.load = 0; if2.seed = '0; if2.mode = 0;

        for (int d = 0; d < 3; d++) drv(d, 1, 0, 0, 0, 0, "rst");
        drv(0, 1, 0, 0, 0, 0, "t1_rst");
        chk("t1_q_ffff", a_q, 32'hFFFF);
        for (int i = 0; i < 10; i++) drv(0, 0, 0, 0, 0, 0, "t1_idle");
        chk("t1_hold", a_q, 32'hFFFF);

        drv(0, 0, 1, 0, 32'hACE1, 0, "t2_ld");
        drv(0, 0, 0, 1, 0, 0, "t2_e1");
        chk("t2_q1", a_q, 32'h5670); chk("t2_c1", a_cnt, 32'd1);
        drv(0, 0, 0, 1, 0, 0, "t2_e2");
        chk("t2_q2", a_q, 32'hAB38); chk("t2_c2", a_cnt, 32'd2);
        drv(0, 0, 0, 1, 0, 1, "t2_mode1");
        drv(0, 0, 0, 1, 0, 0, "t2_mode0");

        drv(0, 0, 1, 0, 32'hACE1, 1, "t3_ld");
        drv(0, 0, 0, 1, 0, 1, "t3_e");
        chk("t3_q", a_q, 32'hE270); chk("t3_b", a_bits, 32'd1);
        drv(1, 0, 1, 0, 32'hACE1, 1, "t3s2_ld");
        drv(1, 0, 0, 1, 0, 1, "t3s2_e");
        chk("t3s2_q", a_q, 32'h7138); chk("t3s2_b", a_bits, 32'b01);
        for (int i = 0; i < 4; i++) drv(1, 0, 0, 1, 0, i[0], "t3s2_run");

        drv(0, 0, 1, 0, 32'h0001, 1, "t4g_ld");
        full_period(0, 65535, "t4g");
        chk("t4g_q", a_q, 32'h0001);
        drv(2, 0, 1, 0, 32'h01, 0, "t4f_ld");
        full_period(2, 255, "t4f");
        chk("t4f_q", a_q, 32'h01);

        drv(0, 0, 1, 0, 32'h0, 0, "t5_zero");
        chk("t5_q", a_q, 32'hFFFF); chk("t5_zs", 32'(a_zs), 32'd1);
        drv(0, 0, 0, 0, 0, 0, "t5_idle");
        chk("t5_zs_clr", 32'(a_zs), 32'd0);
        drv(0, 0, 0, 1, 0, 0, "t5_en");
        drv(0, 0, 1, 1, 32'hACE1, 0, "t5_ldEn");
        chk("t5_ldq", a_q, 32'hACE1); chk("t5_ldc", a_cnt, 32'd0);

        for (int i = 0; i < 3; i++) drv(0, 0, 0, 1, 0, 0, "t6_run");
        drv(0, 1, 1, 1, 32'h1234, 0, "t6_rst");
        chk("t6_q", a_q, 32'hFFFF); chk("t6_c", a_cnt, 32'd0);
        drv(2, 0, 1, 0, 32'h5A, 1, "t6s_ld");
        for (int i = 0; i < 5; i++) drv(2, 0, 0, 1, 0, 1, "t6s_run");
        drv(2, 1, 1, 1, 32'h33, 0, "t6s_rst");
        chk("t6s_q", a_q, 32'hFF);
        full_period(2, 255, "t6f");
        chk("t6f_q", a_q, 32'hFF);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
